// File: rtl/counter_sequencer_pkg.sv
// ============================================================================
// counter_sequencer_pkg : shared state encoding, requester ids, default width
// Revision 1.0
// ============================================================================
`default_nettype none

package counter_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ACK    = 3'd4,
    ST_REJECT = 3'd5
  } state_t;

  localparam logic [1:0] ID_A   = 2'd0;
  localparam logic [1:0] ID_B   = 2'd1;
  localparam logic [1:0] ID_CLR = 2'd2;

endpackage

`default_nettype wire

// File: rtl/counter_sequencer_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, history moves only on strobed grants
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic [1:0] gnt
);

  // Set means requester 1 (B) was served most recently, so A wins a tie.
  logic last_b_q;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last_b_q);
    gnt[1] = req[1] & (~req[0] | ~last_b_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b_q <= 1'b1;
    end else if (gnt_en && (gnt != 2'b00)) begin
      last_b_q <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// counter_sequencer : arbitrates step/clear requests onto an external counter
// Revision 1.0
// ============================================================================
`default_nettype none

module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             dir_a,
  input  logic             req_b,
  input  logic             dir_b,
  input  logic             clr_req,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             cnt_up,
  output logic             cnt_down,
  output logic             cnt_en,
  output logic             cnt_rst,
  output logic             ack_a,
  output logic             ack_b,
  output logic             nack_a,
  output logic             nack_b,
  output logic             clr_ack,
  output logic             full,
  output logic             empty,
  output logic             seq_err
);

  state_t           state_q;
  logic [1:0]       id_q;
  logic [WIDTH-1:0] expected_q;
  logic             seq_err_q;
  logic             cnt_up_q, cnt_down_q, cnt_en_q, cnt_rst_q;
  logic             ack_a_q, ack_b_q, nack_a_q, nack_b_q, clr_ack_q;

  logic [1:0] gnt;
  logic       gnt_en;
  logic       win_dir;
  logic       win_reject;

  assign full    = (cnt_in == {WIDTH{1'b1}});
  assign empty   = (cnt_in == '0);
  assign gnt_en  = (state_q == ST_IDLE) && !clr_req;
  assign win_dir = gnt[1] ? dir_b : dir_a;
  // Stepping past either end would wrap the counter, so it is refused instead.
  assign win_reject = (win_dir && full) || (!win_dir && empty);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req_b, req_a}),
    .gnt_en (gnt_en),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      id_q       <= ID_A;
      expected_q <= '0;
      seq_err_q  <= 1'b0;
      cnt_up_q   <= 1'b0;
      cnt_down_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_rst_q  <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      nack_a_q   <= 1'b0;
      nack_b_q   <= 1'b0;
      clr_ack_q  <= 1'b0;
    end else begin
      cnt_up_q   <= 1'b0;
      cnt_down_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_rst_q  <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      nack_a_q   <= 1'b0;
      nack_b_q   <= 1'b0;
      clr_ack_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            id_q       <= ID_CLR;
            expected_q <= '0;
            cnt_rst_q  <= 1'b1;
          end else if (gnt != 2'b00) begin
            id_q       <= gnt[1] ? ID_B : ID_A;
            expected_q <= win_dir ? cnt_in + WIDTH'(1) : cnt_in - WIDTH'(1);
            if (win_reject) begin
              state_q  <= ST_REJECT;
              nack_a_q <= gnt[0];
              nack_b_q <= gnt[1];
            end else begin
              state_q    <= ST_ISSUE;
              cnt_en_q   <= 1'b1;
              cnt_up_q   <= win_dir;
              cnt_down_q <= !win_dir;
            end
          end
        end
        ST_ISSUE, ST_CLEAR: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state_q   <= ST_ACK;
          ack_a_q   <= (id_q == ID_A);
          ack_b_q   <= (id_q == ID_B);
          clr_ack_q <= (id_q == ID_CLR);
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          if (cnt_in != expected_q) begin
            seq_err_q <= 1'b1;
          end
        end
        ST_REJECT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cnt_up   = cnt_up_q;
  assign cnt_down = cnt_down_q;
  assign cnt_en   = cnt_en_q;
  assign cnt_rst  = cnt_rst_q;
  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign nack_a   = nack_a_q;
  assign nack_b   = nack_b_q;
  assign clr_ack  = clr_ack_q;
  assign seq_err  = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ============================================================================
// tb_counter_sequencer : directed + random transaction-level checks
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_counter_sequencer;

  localparam int W   = 3;
  localparam int MAX = (1 << W) - 1;

  localparam int EV_A  = 1;
  localparam int EV_B  = 2;
  localparam int EV_NA = 3;
  localparam int EV_NB = 4;
  localparam int EV_C  = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_a = 1'b0, dir_a = 1'b0, req_b = 1'b0, dir_b = 1'b0, clr_req = 1'b0;
  logic [W-1:0] cnt;
  logic         cnt_up, cnt_down, cnt_en, cnt_rst;
  logic         ack_a, ack_b, nack_a, nack_b, clr_ack, full, empty, seq_err;

  // External counter model; freeze makes it ignore its enable.
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         freeze = 1'b0;

  always @(posedge clk) begin
    if (load_en)      cnt <= load_val;
    else if (cnt_rst) cnt <= '0;
    else if (cnt_en && !freeze) cnt <= cnt_up ? cnt + 1'b1 : cnt - 1'b1;
  end

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .dir_a(dir_a), .req_b(req_b), .dir_b(dir_b),
    .clr_req(clr_req), .cnt_in(cnt),
    .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_en(cnt_en), .cnt_rst(cnt_rst),
    .ack_a(ack_a), .ack_b(ack_b), .nack_a(nack_a), .nack_b(nack_b),
    .clr_ack(clr_ack), .full(full), .empty(empty), .seq_err(seq_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: who was served last, and whether an error is latched.
  bit m_last_b = 1'b1;
  bit m_seq_err = 1'b0;

  int got_q[$];
  int got_k[$];
  int first_en_k, first_rst_k, en_cycles, bad_drive, bad_decode;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({cnt_up, cnt_down, cnt_en, cnt_rst, ack_a, ack_b,
                 nack_a, nack_b, clr_ack, seq_err});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0; clr_req = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_last_b = 1'b1;
    m_seq_err = 1'b0;
  endtask

  task automatic preload(input logic [W-1:0] v);
    load_en = 1'b1; load_val = v;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Serve na steps of A, nb steps of B and optionally one clear, each requester
  // re-raising its request one cycle after every ack/nack. Expected outcomes
  // come from the ordering rules: clear first, then round-robin, saturating ends.
  task automatic run_batch(input string tag, input int na, input bit da,
                           input int nb, input bit db, input bit rc,
                           input logic [W-1:0] start);
    int exp_q[$];
    int ma = na, mb = nb;
    bit mc = rc;
    int mcnt = int'(start);
    int rem_a = na, rem_b = nb;
    bit rem_c = rc;
    int n;

    while (mc || ma > 0 || mb > 0) begin
      if (mc) begin
        exp_q.push_back(EV_C);
        mcnt = 0;
        mc = 1'b0;
      end else begin
        bit pick_b = (mb > 0) && (ma == 0 || !m_last_b);
        bit d = pick_b ? db : da;
        m_last_b = pick_b;
        if (pick_b) mb--; else ma--;
        if ((d && mcnt == MAX) || (!d && mcnt == 0)) begin
          exp_q.push_back(pick_b ? EV_NB : EV_NA);
        end else begin
          exp_q.push_back(pick_b ? EV_B : EV_A);
          if (freeze) m_seq_err = 1'b1;
          else mcnt = d ? mcnt + 1 : mcnt - 1;
        end
      end
    end

    preload(start);
    got_q.delete(); got_k.delete();
    first_en_k = -1; first_rst_k = -1; en_cycles = 0; bad_drive = 0; bad_decode = 0;
    dir_a = da; dir_b = db;
    req_a = (rem_a > 0); req_b = (rem_b > 0); clr_req = rc;
    for (int k = 1; k <= 80 && (rem_a > 0 || rem_b > 0 || rem_c); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cnt_en) begin
        en_cycles++;
        if (first_en_k < 0) first_en_k = k;
      end
      if (cnt_rst && first_rst_k < 0) first_rst_k = k;
      if ((cnt_up && cnt_down) || ((cnt_up || cnt_down) && !cnt_en)) bad_drive++;
      if (full != (int'(cnt) == MAX) || empty != (cnt == '0)) bad_decode++;
      if (ack_a)   begin got_q.push_back(EV_A);  got_k.push_back(k); end
      if (ack_b)   begin got_q.push_back(EV_B);  got_k.push_back(k); end
      if (nack_a)  begin got_q.push_back(EV_NA); got_k.push_back(k); end
      if (nack_b)  begin got_q.push_back(EV_NB); got_k.push_back(k); end
      if (clr_ack) begin got_q.push_back(EV_C);  got_k.push_back(k); end
      if (ack_a || nack_a) begin rem_a--; req_a = 1'b0; end else req_a = (rem_a > 0);
      if (ack_b || nack_b) begin rem_b--; req_b = 1'b0; end else req_b = (rem_b > 0);
      if (clr_ack) begin rem_c = 1'b0; clr_req = 1'b0; end
    end
    req_a = 1'b0; req_b = 1'b0; clr_req = 1'b0;
    check({tag, "_done"}, int'(rem_a > 0 || rem_b > 0 || rem_c), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_nevents"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, got_q[i], exp_q[i]);
    check({tag, "_count"}, int'(cnt), mcnt);
    check({tag, "_drive"}, bad_drive, 0);
    check({tag, "_decode"}, bad_decode, 0);
    check({tag, "_seq_err"}, int'(seq_err), int'(m_seq_err));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    preload('0);
    reset = 1'b0;
    #1;
    check("reset_outputs", out_vec(), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    do_reset();

    // Round-robin after reset: A, B, A from cnt 2 up to 5
    run_batch("rr_abab", 2, 1'b1, 1, 1'b1, 1'b0, 3'd2);

    // Single step latency from an idle sequencer
    run_batch("step_a", 1, 1'b1, 0, 1'b0, 1'b0, 3'd0);
    check("step_en_latency", first_en_k, 1);
    check("step_ack_latency", got_k.size() > 0 ? got_k[0] : -1, 3);

    // Saturation rejects
    run_batch("rej_b_full", 0, 1'b0, 1, 1'b1, 1'b0, 3'd7);
    check("rej_b_latency", got_k.size() > 0 ? got_k[0] : -1, 1);
    check("rej_b_no_en", en_cycles, 0);
    run_batch("rej_a_empty", 1, 1'b0, 0, 1'b0, 1'b0, 3'd0);
    check("rej_a_no_en", en_cycles, 0);

    // Clear beats a simultaneous step
    run_batch("clr_then_a", 1, 1'b1, 0, 1'b0, 1'b1, 3'd4);
    check("clr_rst_latency", first_rst_k, 1);
    check("clr_ack_latency", got_k.size() > 0 ? got_k[0] : -1, 3);

    // Counter ignores its enable: sticky sequence error
    freeze = 1'b1;
    run_batch("frozen", 1, 1'b1, 0, 1'b0, 1'b0, 3'd3);
    freeze = 1'b0;
    run_batch("after_frozen", 0, 1'b0, 1, 1'b0, 1'b0, 3'd5);
    do_reset();
    check("seq_err_reset", int'(seq_err), 0);

    // Reset while settling aborts the step
    preload(3'd2);
    req_a = 1'b1; dir_a = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_outputs", out_vec(), 0);
    req_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_last_b = 1'b1;
    m_seq_err = 1'b0;
    begin
      int acks = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); @(negedge clk);
        if (ack_a || ack_b || clr_ack || nack_a || nack_b || cnt_en) acks++;
      end
      check("midreset_no_ack", acks, 0);
    end
    run_batch("post_reset", 1, 1'b0, 0, 1'b0, 1'b0, 3'd6);
    check("post_reset_en_latency", first_en_k, 1);

    // Randomized batches
    for (int r = 0; r < 25; r++) begin
      int na = $urandom_range(0, 2);
      int nb = $urandom_range(0, 2);
      bit rc = 1'($urandom_range(0, 3) == 0);
      if (na == 0 && nb == 0 && !rc) na = 1;
      run_batch("rand", na, 1'($urandom), nb, 1'($urandom), rc, 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter WIDTH, default 3: width of the controlled up/down counter.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_a  input  1  requester A wants one count step; held until ack_a or nack_a.
REQ-005 dir_a  input  1  requester A direction: 1 = up, 0 = down; stable while req_a is high.
REQ-006 req_b, dir_b  input  1 each  requester B, same semantics as A.
REQ-007 clr_req  input  1  request to clear the counter to 0; held until clr_ack.
REQ-008 cnt_in  input  WIDTH  current counter value, fed back from the counter.
REQ-009 cnt_up, cnt_down, cnt_en  output  1 each  drive the counter's up, down and enable inputs.
REQ-010 cnt_rst  output  1  drives the counter's synchronous active-high reset.
REQ-011 ack_a, ack_b, nack_a, nack_b, clr_ack  output  1 each  one-cycle completion pulses.
REQ-012 full, empty  output  1 each  combinational decodes of cnt_in: full when cnt_in == 2^WIDTH-1, empty when cnt_in == 0.
REQ-013 seq_err  output  1  sticky flag: the counter failed to reach the expected value.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, CLEAR, SETTLE, ACK and REJECT, with registered state.
REQ-015 In IDLE, clr_req SHALL take priority over req_a and req_b; the next state is CLEAR.
REQ-016 Without clr_req, if req_a and req_b are both high, the requester not served last SHALL win (round-robin); after reset, A wins first.
REQ-017 On a grant, the winner id, its direction and expected = cnt_in ± 1 SHALL be latched.
REQ-018 If the winner requests up while full, or down while empty, the next state SHALL be REJECT; otherwise it SHALL be ISSUE.
REQ-019 ISSUE lasts exactly 1 cycle: cnt_en = 1, and exactly one of cnt_up or cnt_down = 1 per the latched direction; the next state is SETTLE.
REQ-020 CLEAR lasts 1 cycle: cnt_rst = 1, expected = 0; the next state is SETTLE.
REQ-021 SETTLE lasts 1 cycle with no counter drive; the next state is ACK.
REQ-022 ACK lasts 1 cycle and pulses the ack of the latched requester (ack_a, ack_b or clr_ack).
  - If cnt_in != expected in this cycle, seq_err SHALL be set.
  - The next state is IDLE.
REQ-023 REJECT lasts 1 cycle, pulses nack_a or nack_b, and does not drive the counter; the next state is IDLE.
REQ-024 Latency from the IDLE grant cycle T:
  - step: cnt_en at T+1, ack at T+3;
  - clear: cnt_rst at T+1, clr_ack at T+3;
  - reject: nack at T+1.
REQ-025 Round-robin history SHALL update on every grant to A or B, including grants that end in REJECT; a clear SHALL NOT change it.
REQ-026 Requesters deassert req in the cycle after their ack or nack; the next IDLE samples that cycle, so the counter never double-steps.
REQ-027 cnt_en, cnt_up, cnt_down and cnt_rst SHALL be 0 in every state except ISSUE or CLEAR as specified; cnt_up and cnt_down SHALL never both be 1.
REQ-028 Counter wrap-around SHALL never be commanded; the counter saturates logically at 0 and 2^WIDTH-1 through REJECT.
REQ-029 Requests arriving outside IDLE SHALL wait, not be lost, as long as they are held.

Reset
REQ-030 reset low SHALL asynchronously force:
  - state = IDLE, all ack/nack/drive outputs = 0;
  - seq_err = 0, expected = 0, round-robin history = "B served last".
REQ-031 reset asserted mid-operation SHALL abort the operation with no ack; the requester must re-request.
REQ-032 seq_err SHALL clear only through reset.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the requester-id constants (ID_A, ID_B, ID_CLR) and the default WIDTH.
REQ-034 The two-way round-robin choice SHALL be a sub-module rr_arb2: inputs req[1:0], a grant-enable strobe, clk and reset; output one-hot gnt[1:0].

Verification
REQ-035 Reset, cnt_in = 0, req_a = 1, dir_a = 1 at cycle 0 -> cnt_en = cnt_up = 1 at cycle 1, ack_a at cycle 3, counter reads 1.
REQ-036 req_a and req_b both up, held, cnt_in = 2 -> grants alternate A, B, A; the counter reaches 5; no cycle has cnt_en with both cnt_up and cnt_down.
REQ-037 cnt_in = 7, req_b up -> nack_b one cycle after the grant, cnt_en never asserted; cnt_in = 0, req_a down -> nack_a.
REQ-038 clr_req and req_a both high with cnt_in = 4 -> cnt_rst pulse first, then clr_ack, counter 0; the A step is served afterwards.
REQ-039 Counter model holds its value, ignoring the enable, during a step -> seq_err = 1 at ACK and it stays 1 until reset.
REQ-040 reset pulsed low during SETTLE -> all outputs 0 immediately, no ack is issued, and the FSM is in IDLE after reset is released.
